// File: rtl/ram_loader_pkg.sv
// Shared definitions for the RAM loader: default widths and FSM state encoding.
// Pure declarations, no logic.
// Imported by ram_loader.
package ram_loader_pkg;

  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 1 << AW_DEF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECV   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_FIN    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/ram_loader.sv
// Streams bytes from a valid/ready source into consecutive RAM words, holding the CPU in prog mode.
// Latency: byte accepted cycle N -> mem_we cycle N+1 (readback compare N+2 with verify); 1 word/2 cycles (3 with verify).
// Backpressure: in_ready only in RECV; source may stall indefinitely. Readback verify: RAM_LOADER_VERIFY_EN.
import ram_loader_pkg::*;

module ram_loader #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          prog,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] csum
);

  loader_state_t r_state;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] r_rem;      // words left incl. current; len=0 wraps to DEPTH naturally
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_csum;
  logic          r_in_ready;
  logic          r_mem_we;
  logic          r_prog;
  logic          r_done;
  logic          r_err;
  logic          w_last;

  assign w_last = (r_rem == {{(AW-1){1'b0}}, 1'b1});

  // Single FSM: all outputs registered and updated on the transition into each state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_wdata    <= '0;
      r_csum     <= '0;
      r_in_ready <= 1'b0;
      r_mem_we   <= 1'b0;
      r_prog     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr     <= base;
            r_rem      <= len;
            r_csum     <= '0;
            r_err      <= 1'b0;
            r_prog     <= 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (in_valid) begin
            r_wdata    <= in_data;
            r_csum     <= r_csum + in_data;
            r_in_ready <= 1'b0;
            r_mem_we   <= 1'b1;
            r_state    <= ST_WRITE;
          end
        end
`ifdef RAM_LOADER_VERIFY_EN
        ST_WRITE: begin
          r_state <= ST_VERIFY;
        end
        ST_VERIFY: begin
          if (mem_rdata != r_wdata) begin
            r_err   <= 1'b1;
            r_prog  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else if (w_last) begin
            r_prog  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_addr     <= r_addr + 1'b1;
            r_rem      <= r_rem - 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= ST_RECV;
          end
        end
`else
        ST_WRITE: begin
          if (w_last) begin
            r_prog  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_addr     <= r_addr + 1'b1;
            r_rem      <= r_rem - 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= ST_RECV;
          end
        end
`endif
        ST_FIN: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_prog     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign prog      = r_prog;
  assign done      = r_done;
  assign csum      = r_csum;

`ifdef RAM_LOADER_VERIFY_EN
  assign err = r_err;
`else
  // Without readback there is nothing to flag; the register folds away
  logic w_unused_rdata;
  assign w_unused_rdata = ^{mem_rdata, r_err};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: RAM model plus write scoreboard.
// Expected writes are queued as bytes are driven and popped as mem_we strobes appear.
// Runs in both default and RAM_LOADER_VERIFY_EN builds.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] base;
  logic [3:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       prog;
  logic       done;
  logic       err;
  logic [7:0] csum;

  always #5 clk = ~clk;

  ram_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .prog(prog), .done(done), .err(err), .csum(csum)
  );

  // RAM model with an injectable read fault at address 3
  logic [7:0] ram [16];
  logic       force_bad = 1'b0;
  assign mem_rdata = (force_bad && mem_addr == 4'd3) ? 8'hFF : ram[mem_addr];
  always @(posedge clk) if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;

  typedef struct packed { logic [3:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;
  int  n_wr     = 0;
  int  n_done   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (mem_we === 1'b1) begin
        wr_t got;
        n_wr++;
        chk("in_ready_low_in_write", {31'd0, in_ready}, 32'd0);
        chk("write_was_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          chk("write_addr", {28'd0, mem_addr}, {28'd0, got.a});
          chk("write_data", {24'd0, mem_wdata}, {24'd0, got.d});
        end
      end
      if (done === 1'b1) n_done++;
    end
  end

  task automatic do_start(input logic [3:0] b, input logic [3:0] l);
    start = 1'b1; base = b; len = l;
    @(negedge clk);
    start = 1'b0;
    chk("start_prog", {31'd0, prog}, 32'd1);
    chk("start_in_ready", {31'd0, in_ready}, 32'd1);
    chk("start_csum_clr", {24'd0, csum}, 32'd0);
    chk("start_err_clr", {31'd0, err}, 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1; in_data = d;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("accept_timeout", t, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("prog_low_at_done", {31'd0, prog}, 32'd0);
  endtask

  task automatic post_done(input int n_exp_wr);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("done_count", n_done, 1);
    chk("write_count", n_wr, n_exp_wr);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic run_load(input logic [3:0] b, input logic [3:0] l, input int n,
                          input logic [7:0] first, input int maxgap);
    logic [7:0] sum;
    logic [7:0] d;
    sum = 8'd0; n_wr = 0; n_done = 0;
    do_start(b, l);
    for (int i = 0; i < n; i++) begin
      d = first + 8'(i);
      exp_q.push_back('{a: b + 4'(i), d: d});
      sum = sum + d;
      send_byte(d, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    end
    wait_done();
    chk("csum", {24'd0, csum}, {24'd0, sum});
    chk("addr_hold_last", {28'd0, mem_addr}, {28'd0, b + 4'(n - 1)});
    post_done(n);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base = '0; len = '0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    #12;
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_prog", {31'd0, prog}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_addr", {28'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_csum", {24'd0, csum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-depth load: len=0 means 16 words, checksum of 0x10..0x1F is 0x78
    run_load(4'd0, 4'd0, 16, 8'h10, 0);
    chk("full_csum_const", {24'd0, csum}, 32'h78);

    // Address wrap 14,15,0,1
    run_load(4'd14, 4'd4, 4, 8'hA1, 0);
    chk("wrap_csum_const", {24'd0, csum}, 32'h8A);

    // Random source gaps of 0..5 cycles
    run_load(4'd5, 4'd6, 6, 8'h30, 5);

    // start during RECV must not disturb base/len
    n_wr = 0; n_done = 0;
    do_start(4'd2, 4'd2);
    start = 1'b1; base = 4'd9; len = 4'd5;
    @(negedge clk);
    start = 1'b0;
    chk("recv_start_addr", {28'd0, mem_addr}, 32'd2);
    exp_q.push_back('{a: 4'd2, d: 8'h61});
    send_byte(8'h61, 0);
    exp_q.push_back('{a: 4'd3, d: 8'h62});
    send_byte(8'h62, 1);
    wait_done();
    chk("recv_start_csum", {24'd0, csum}, 32'hC3);
    post_done(2);

`ifdef RAM_LOADER_VERIFY_EN
    // Readback failure at address 3 stops the load before address 4
    force_bad = 1'b1;
    n_wr = 0; n_done = 0;
    do_start(4'd0, 4'd8);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{a: 4'(i), d: 8'h40 + 8'(i)});
      send_byte(8'h40 + 8'(i), 0);
    end
    wait_done();
    chk("verify_err_set", {31'd0, err}, 32'd1);
    post_done(4);
    repeat (5) @(negedge clk);
    chk("verify_no_more_writes", n_wr, 4);
    chk("verify_err_sticky", {31'd0, err}, 32'd1);
    force_bad = 1'b0;
    run_load(4'd7, 4'd1, 1, 8'h5A, 0);
    chk("verify_err_cleared", {31'd0, err}, 32'd0);
`endif

    // Reset asserted while the 5th word is being written
    n_wr = 0; n_done = 0;
    do_start(4'd0, 4'd10);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{a: 4'(i), d: 8'h20 + 8'(i)});
      send_byte(8'h20 + 8'(i), 0);
    end
    chk("pre_reset_we", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_we", {31'd0, mem_we}, 32'd0);
    chk("async_rst_prog", {31'd0, prog}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("async_rst_csum", {24'd0, csum}, 32'd0);
    chk("pre_reset_writes", n_wr, 5);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_load(4'd8, 4'd2, 2, 8'h55, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
